// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Seconds stage of the BCD stopwatch display chain. A prescaler divides clk
// into count ticks, a units/tens BCD counter runs 00..(TENS_MAX)9, and a
// start/stop/clear/lap FSM sequences the counter and freezes the display on
// lap. tick and wrap let the next digit stage (minutes) cascade.
//
// Parameters:
//   TICK_DIV   clk cycles per count tick (>= 2)
//   TENS_MAX   highest tens digit before the counter wraps to 00
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset, highest priority
//   start_stop  one-cycle pulse, toggles run/pause
//   clear       one-cycle pulse, return to 00 / idle
//   lap         one-cycle pulse, freeze/unfreeze the display while counting
//   disp_units  displayed units digit (BCD)
//   disp_tens   displayed tens digit (BCD)
//   running     high in RUN or LAP
//   lap_active  high in LAP
//   tick        high in the cycle whose closing edge applies an increment
//   wrap        one-cycle pulse in the cycle after the count rolls over to 00
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV = 6,
    parameter int TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] disp_units,
    output logic [3:0] disp_tens,
    output logic       running,
    output logic       lap_active,
    output logic       tick,
    output logic       wrap
);

    localparam int              PRE_W     = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]      TENS_LAST = 4'(TENS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t           state_r;
    logic [PRE_W-1:0] presc_r;
    logic [3:0]       units_r;
    logic [3:0]       tens_r;
    logic [3:0]       lap_units_r;
    logic [3:0]       lap_tens_r;
    logic             wrap_r;

    logic             counting_s;
    logic             tick_s;
    logic [3:0]       units_nxt_s;
    logic [3:0]       tens_nxt_s;
    logic             wrap_nxt_s;

    // Prescaler and counter only advance while the stopwatch is counting.
    always_comb begin
        counting_s = (state_r == ST_RUN) || (state_r == ST_LAP);
        // ">=" keeps a corrupted prescaler from stalling the count forever.
        tick_s     = counting_s && (presc_r >= PRE_LAST);
    end

    // Next BCD value; out-of-range digits are treated as their maximum so the
    // counter always falls back into range on the next tick.
    always_comb begin
        units_nxt_s = 4'd0;
        tens_nxt_s  = tens_r;
        wrap_nxt_s  = 1'b0;
        if (units_r < 4'd9) begin
            units_nxt_s = units_r + 4'd1;
        end else if (tens_r < TENS_LAST) begin
            units_nxt_s = 4'd0;
            tens_nxt_s  = tens_r + 4'd1;
        end else begin
            units_nxt_s = 4'd0;
            tens_nxt_s  = 4'd0;
            wrap_nxt_s  = 1'b1;
        end
    end

    // Control FSM, prescaler, live digits, lap capture and wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            presc_r     <= '0;
            units_r     <= 4'd0;
            tens_r      <= 4'd0;
            lap_units_r <= 4'd0;
            lap_tens_r  <= 4'd0;
            wrap_r      <= 1'b0;
        end else if (clear) begin
            // clear outranks a same-cycle tick: result is 00 with no wrap.
            state_r     <= ST_IDLE;
            presc_r     <= '0;
            units_r     <= 4'd0;
            tens_r      <= 4'd0;
            lap_units_r <= 4'd0;
            lap_tens_r  <= 4'd0;
            wrap_r      <= 1'b0;
        end else begin
            wrap_r <= 1'b0;

            // Counting follows the current state, so a tick coinciding with
            // start_stop or lap is still applied.
            if (counting_s) begin
                if (tick_s) begin
                    presc_r <= '0;
                    units_r <= units_nxt_s;
                    tens_r  <= tens_nxt_s;
                    wrap_r  <= wrap_nxt_s;
                end else begin
                    presc_r <= presc_r + PRE_W'(1);
                end
            end else begin
                presc_r <= presc_r;
            end

            // start_stop outranks lap; a dropped lap pulse has no effect.
            case (state_r)
                ST_IDLE: begin
                    if (start_stop) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state_r <= ST_PAUSE;
                    end else if (lap) begin
                        // Capture the pre-increment value of this edge.
                        state_r     <= ST_LAP;
                        lap_units_r <= units_r;
                        lap_tens_r  <= tens_r;
                    end
                end
                ST_LAP: begin
                    if (start_stop) begin
                        state_r <= ST_PAUSE;
                    end else if (lap) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Display mux and status decode, all taken straight from registers.
    always_comb begin
        if (state_r == ST_LAP) begin
            disp_units = lap_units_r;
            disp_tens  = lap_tens_r;
        end else begin
            disp_units = units_r;
            disp_tens  = tens_r;
        end
        running    = counting_s;
        lap_active = (state_r == ST_LAP);
        tick       = tick_s;
        wrap       = wrap_r;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Drives stopwatch_ctrl cycle by cycle. Every driven cycle steps a behavioural
// model (count kept as a plain 0..59 integer) and pushes the expected outputs
// into a scoreboard queue; after the clock edge the entry is popped and
// compared with the DUT. Directed checks pin the key timing points.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 6;
    localparam int TENS_MAX = 5;
    localparam int MAX_CNT  = TENS_MAX * 10 + 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] disp_units;
    logic [3:0] disp_tens;
    logic       running;
    logic       lap_active;
    logic       tick;
    logic       wrap;

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV),
        .TENS_MAX (TENS_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .disp_units (disp_units),
        .disp_tens  (disp_tens),
        .running    (running),
        .lap_active (lap_active),
        .tick       (tick),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 run, 2 lap, 3 pause.
    int m_st   = 0;
    int m_pre  = 0;
    int m_cnt  = 0;
    int m_lapc = 0;
    int m_wr   = 0;

    typedef struct packed {
        logic [31:0] u;
        logic [31:0] t;
        logic [31:0] run;
        logic [31:0] lapa;
        logic [31:0] tk;
        logic [31:0] wr;
    } exp_t;

    exp_t exp_q[$];

    task automatic model_step(input bit rs, input bit ss, input bit cl, input bit lp);
        int tk;
        int ncnt;
        if (rs) begin
            m_st = 0; m_pre = 0; m_cnt = 0; m_lapc = 0; m_wr = 0;
        end else begin
            tk   = ((m_st == 1 || m_st == 2) && m_pre == TICK_DIV - 1) ? 1 : 0;
            m_wr = 0;
            if (cl) begin
                m_st = 0; m_pre = 0; m_cnt = 0; m_lapc = 0;
            end else begin
                ncnt = m_cnt;
                if (m_st == 1 || m_st == 2) begin
                    if (tk == 1) begin
                        m_pre = 0;
                        if (m_cnt == MAX_CNT) begin
                            ncnt = 0;
                            m_wr = 1;
                        end else begin
                            ncnt = m_cnt + 1;
                        end
                    end else begin
                        m_pre = m_pre + 1;
                    end
                end
                case (m_st)
                    0: if (ss) m_st = 1;
                    1: if (ss) m_st = 3; else if (lp) begin m_st = 2; m_lapc = m_cnt; end
                    2: if (ss) m_st = 3; else if (lp) m_st = 1;
                    3: if (ss) m_st = 1;
                    default: m_st = 0;
                endcase
                m_cnt = ncnt;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   d;
        d      = (m_st == 2) ? m_lapc : m_cnt;
        e.u    = d % 10;
        e.t    = d / 10;
        e.run  = (m_st == 1 || m_st == 2) ? 1 : 0;
        e.lapa = (m_st == 2) ? 1 : 0;
        e.tk   = ((m_st == 1 || m_st == 2) && m_pre == TICK_DIV - 1) ? 1 : 0;
        e.wr   = m_wr;
        return e;
    endfunction

    // One clock cycle: drive, predict, wait for the edge, compare.
    task automatic cycle(input bit rs, input bit ss, input bit cl, input bit lp);
        exp_t e;
        reset      = rs;
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        model_step(rs, ss, cl, lp);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        reset      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        e = exp_q.pop_front();
        check_val("sb_units", disp_units, e.u);
        check_val("sb_tens", disp_tens, e.t);
        check_val("sb_running", running, e.run);
        check_val("sb_lap_active", lap_active, e.lapa);
        check_val("sb_tick", tick, e.tk);
        check_val("sb_wrap", wrap, e.wr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Idle-clock until the live count reaches target (bounded).
    task automatic run_to(input int target);
        bit done;
        done = (m_cnt == target);
        for (int i = 0; i < 1000 && !done; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            done = (m_cnt == target);
        end
        check_val("run_to_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rst_units", disp_units, 32'd0);
        check_val("rst_tens", disp_tens, 32'd0);
        check_val("rst_running", running, 32'd0);
        check_val("rst_tick", tick, 32'd0);
        check_val("rst_wrap", wrap, 32'd0);

        // First increment lands TICK_DIV edges after entering RUN.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("start_running", running, 32'd1);
        run(5);
        check_val("first_tick_pulse", tick, 32'd1);
        check_val("first_pre_units", disp_units, 32'd0);
        run(1);
        check_val("first_units", disp_units, 32'd1);
        check_val("first_tick_low", tick, 32'd0);
        run(54);
        check_val("ten_tens", disp_tens, 32'd1);
        check_val("ten_units", disp_units, 32'd0);

        // Full rollover 59 -> 00 with a single-cycle wrap.
        run(299);
        check_val("pre_wrap_tens", disp_tens, 32'd5);
        check_val("pre_wrap_units", disp_units, 32'd9);
        check_val("pre_wrap_tick", tick, 32'd1);
        check_val("pre_wrap_wrap", wrap, 32'd0);
        run(1);
        check_val("wrap_high", wrap, 32'd1);
        check_val("wrap_units", disp_units, 32'd0);
        check_val("wrap_tens", disp_tens, 32'd0);
        check_val("wrap_running", running, 32'd1);
        run(1);
        check_val("wrap_low", wrap, 32'd0);

        // Pause with a partial prescaler period, then resume.
        run(1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("pause_running", running, 32'd0);
        run(20);
        check_val("pause_units", disp_units, 32'd0);
        check_val("pause_tick", tick, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run(2);
        check_val("resume_units_before", disp_units, 32'd0);
        run(1);
        check_val("resume_units_after", disp_units, 32'd1);

        // Lap freeze at 12, release at 17.
        run_to(12);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("lap_active_on", lap_active, 32'd1);
        run(12);
        check_val("lap_frozen_tens", disp_tens, 32'd1);
        check_val("lap_frozen_units", disp_units, 32'd2);
        check_val("lap_running", running, 32'd1);
        run_to(17);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("unlap_active", lap_active, 32'd0);
        check_val("unlap_tens", disp_tens, 32'd1);
        check_val("unlap_units", disp_units, 32'd7);

        // clear and start_stop together at 34: clear wins.
        run_to(34);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("clr_running", running, 32'd0);
        check_val("clr_units", disp_units, 32'd0);
        check_val("clr_tens", disp_tens, 32'd0);
        check_val("clr_wrap", wrap, 32'd0);
        run(10);
        check_val("clr_idle_units", disp_units, 32'd0);

        // Reset mid-LAP at 45, then restart from 00.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_to(45);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("lap45_active", lap_active, 32'd1);
        run(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rst45_units", disp_units, 32'd0);
        check_val("rst45_tens", disp_tens, 32'd0);
        check_val("rst45_running", running, 32'd0);
        check_val("rst45_lap", lap_active, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run(6);
        check_val("restart_units", disp_units, 32'd1);
        check_val("restart_tens", disp_tens, 32'd0);

        // Lap in a tick cycle captures the pre-increment value.
        run(5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("tick_lap_units", disp_units, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("tick_unlap_units", disp_units, 32'd2);

        // clear in the tick cycle at 59 suppresses the wrap.
        run_to(59);
        run(5);
        check_val("clr59_tick", tick, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("clr59_wrap", wrap, 32'd0);
        check_val("clr59_units", disp_units, 32'd0);
        check_val("clr59_tens", disp_tens, 32'd0);

        // Random command traffic, including coincident pulses.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the BCD seconds display chain. It owns a prescaler that divides the system clock into count ticks and a units/tens BCD counter (00..59). A start/stop/clear/lap FSM sequences the counter, freezes the display on lap, and exports a tick and a wrap pulse so the next digit stage (minutes) can cascade.

Parameters:
TICK_DIV, 6, clk cycles per count tick (>=2)
TENS_MAX, 5, highest tens digit before wrap (units always wrap at 9)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears everything on the next rising edge
start_stop  input  1  single-cycle pulse; toggles run/pause
clear  input  1  single-cycle pulse; return to zero/idle
lap  input  1  single-cycle pulse; freeze/unfreeze display while counting
disp_units  output  4  displayed units digit, BCD 0..9
disp_tens  output  4  displayed tens digit, BCD 0..TENS_MAX
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
tick  output  1  one-cycle pulse, the cycle a count increment is applied
wrap  output  1  one-cycle pulse, registered, the cycle after count goes TENS_MAX9 -> 00

Behaviour:
- Reset (sync, highest priority): state IDLE, prescaler 0, live units/tens 0, lap regs 0, wrap 0. All outputs 0 the cycle after reset is sampled.
- Command priority per cycle: reset > clear > start_stop > lap. Only one command acts per cycle; lower-priority pulses that same cycle are dropped.
- States and transitions:
  - IDLE: start_stop -> RUN. clear -> IDLE (no-op). lap ignored.
  - RUN: start_stop -> PAUSE. lap -> LAP, and live digits are copied into the lap regs on that edge. clear -> IDLE.
  - LAP: counting continues. lap -> RUN (display goes live again). start_stop -> PAUSE (display goes live). clear -> IDLE.
  - PAUSE: start_stop -> RUN. clear -> IDLE. lap ignored.
  - Any transition into IDLE zeroes the prescaler, live digits and lap regs on the same edge.
- Prescaler: advances only in RUN/LAP and counts 0..TICK_DIV-1.
  - tick = (state in RUN/LAP) && (prescaler == TICK_DIV-1), combinational from current registers.
  - On tick, the prescaler returns to 0. In PAUSE it holds its value, so a resumed partial period completes; it is not restarted.
- Counting, applied on the edge ending a tick cycle:
  - units < 9: units+1.
  - units == 9, tens < TENS_MAX: units 0, tens+1.
  - units == 9, tens == TENS_MAX: both 0, wrap = 1 for exactly the next cycle.
  - Digits never leave BCD range.
- Simultaneous events:
  - A tick in the same cycle as start_stop (RUN->PAUSE) or lap is still applied, because the current state governs.
  - clear in a tick cycle wins: result is 00, no wrap.
  - A lap capture in a tick cycle captures the pre-increment value.
- Display: disp_* = lap regs in LAP, otherwise live digits (combinational mux of registers; zero added latency).
- Latency: start_stop in RUN at cycle 0 -> first increment visible after the edge ending cycle TICK_DIV-1, i.e. TICK_DIV edges after the RUN state is entered.

Test Plan:
- Reset then start_stop, TICK_DIV=6 -> disp_units 1 after 6 clocks in RUN; tick pulses every 6th cycle; disp 09 -> 10 at tick 10.
- Run 360 cycles from 00 -> disp 59 -> 00, wrap high exactly 1 cycle after the 60th tick, running stays 1.
- Pause after 3 prescaler cycles, hold 20 cycles, resume -> next increment 3 cycles after resume; disp constant while paused.
- lap at 12 -> disp frozen at 12, lap_active 1 while live count advances; lap at live 17 -> disp 17 immediately.
- clear and start_stop in the same cycle during RUN at 34 -> IDLE, disp 00, running 0, no wrap.
- Assert reset mid-LAP at count 45 -> next cycle all outputs 0, state IDLE; start_stop afterwards counts from 00.
